von_control_seq: RTL and testbench

//  Fetch/decode/execute sequencer directly upstream of the 8-bit accumulator ALU.

---
 rtl/von_control_seq_pkg.sv | 40 ++++
 rtl/von_control_seq.sv | 183 ++++++++++++++++++
 tb/tb_von_control_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/von_control_seq_pkg.sv
// ============================================================================
// Module  : von_control_seq_pkg
// Purpose : Shared opcode and sequencer-state definitions for the
//           fetch/decode/execute sequencer and its accumulator ALU.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package von_control_seq_pkg;

  // Opcode field ir[7:5]
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ASL   = 3'b001;
  localparam logic [2:0] OP_XNOR  = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_NEG   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_IF   = 4'd1,
    S_IR   = 4'd2,
    S_OF   = 4'd3,
    S_DR   = 4'd4,
    S_EX   = 4'd5,
    S_WB   = 4'd6,
    S_ST   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  // Opcodes that fetch a memory operand into DR before executing.
  function automatic logic needs_operand(input logic [2:0] op);
    return op inside {OP_ADD, OP_ASL, OP_XNOR, OP_SHR, OP_LOAD};
  endfunction

endpackage

`default_nettype wire

// File: rtl/von_control_seq.sv
// ============================================================================
// Module  : von_control_seq
// Purpose : Fetch/decode/execute sequencer in front of an 8-bit accumulator
//           ALU. Holds PC, IR, AC and DR, fetches instructions and operands
//           from a single-port memory, pulses the ALU and writes its result
//           back to AC, or stores AC to memory. Halts on opcode 111.
// Ports   : clk, rst (sync, active-high), run (level start/continue)
//           mem_addr/mem_re/mem_we/mem_wdata out, mem_rdata in
//           alu_ac/alu_dr/alu_mode/alu_act out, alu_result in
//           pc, halted out
//           step in (only when VON_SINGLE_STEP_EN is defined)
// Config  : VON_SINGLE_STEP_EN - one instruction per rising edge of step;
//           the sequencer always returns to idle after each instruction.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module von_control_seq
  import von_control_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int PC_RST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef VON_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        alu_ac,
  output logic [7:0]        alu_dr,
  output logic [2:0]        alu_mode,
  output logic              alu_act,
  input  logic [7:0]        alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RST);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        ac_q, ac_d;
  logic [7:0]        dr_q, dr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              alu_act_q, alu_act_d;

  logic              start;      // leave S_IDLE this cycle
  state_e            after_ins;  // successor of S_WB / S_ST
  logic [2:0]        fetched_op;

  assign fetched_op = mem_rdata[7:5];

`ifdef VON_SINGLE_STEP_EN
  logic step_q, step_d;
  logic unused_run;

  assign unused_run = run;
  assign step_d     = step;
  // Rising edge of step, so a held-high step still runs one instruction.
  assign start      = step & ~step_q;
  assign after_ins  = S_IDLE;
`else
  assign start      = run;
  // run is only looked at on instruction boundaries; a drop mid-instruction
  // lets the current instruction finish.
  assign after_ins  = run ? S_IF : S_IDLE;
`endif

  // Strobes are registered: the edge leaving S_IF/S_OF/S_EX/S_ST launches the
  // access, and the response is consumed by the following edge.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ac_d        = ac_q;
    dr_d        = dr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    alu_act_d   = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_IF;
      S_IF: begin
        mem_addr_d = pc_q;
        mem_re_d   = 1'b1;
        state_d    = S_IR;
      end
      S_IR: begin
        ir_d = mem_rdata;
        pc_d = pc_q + PC_INC;
        if (needs_operand(fetched_op))  state_d = S_OF;
        else if (fetched_op == OP_NEG)   state_d = S_EX;
        else if (fetched_op == OP_STORE) state_d = S_ST;
        else                             state_d = S_HALT;
      end
      S_OF: begin
        mem_addr_d = ir_q[ADDR_W-1:0];
        mem_re_d   = 1'b1;
        state_d    = S_DR;
      end
      S_DR: begin
        dr_d    = mem_rdata;
        state_d = S_EX;
      end
      S_EX: begin
        alu_act_d = 1'b1;
        state_d   = S_WB;
      end
      S_WB: begin
        ac_d    = alu_result;
        state_d = after_ins;
      end
      S_ST: begin
        mem_addr_d  = ir_q[ADDR_W-1:0];
        mem_we_d    = 1'b1;
        mem_wdata_d = ac_q;
        state_d     = after_ins;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_INIT;
      ir_q        <= 8'h00;
      ac_q        <= 8'h00;
      dr_q        <= 8'h00;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      alu_act_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ac_q        <= ac_d;
      dr_q        <= dr_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      alu_act_q   <= alu_act_d;
    end
  end

`ifdef VON_SINGLE_STEP_EN
  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step_d;
  end
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign alu_ac    = ac_q;
  assign alu_dr    = dr_q;
  assign alu_mode  = ir_q[7:5];
  assign alu_act   = alu_act_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_von_control_seq.sv
// ============================================================================
// Module  : tb_von_control_seq
// Purpose : Self-checking bench for von_control_seq. Random straight-line
//           programs are executed by an instruction-level model and the
//           observed results, cycle counts and memory image are compared.
//           A second instance with PC_RST=31 exercises PC wrap-around.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_von_control_seq;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, run, run2, load_req;
`ifdef VON_SINGLE_STEP_EN
  logic          step;
`endif
  logic [AW-1:0] mem_addr, pc, mem_addr2, pc2;
  logic          mem_re, mem_we, alu_act, halted;
  logic          mem_re2, mem_we2, alu_act2, halted2;
  logic [7:0]    mem_wdata, mem_rdata, alu_ac, alu_dr, alu_result;
  logic [7:0]    mem_wdata2, mem_rdata2, alu_ac2, alu_dr2, alu_result2;
  logic [2:0]    alu_mode, alu_mode2;

  von_control_seq #(.ADDR_W(AW), .PC_RST(0)) u_dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef VON_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_mode(alu_mode),
    .alu_act(alu_act), .alu_result(alu_result),
    .pc(pc), .halted(halted)
  );

  von_control_seq #(.ADDR_W(AW), .PC_RST(31)) u_dut_wrap (
    .clk(clk), .rst(rst), .run(run2),
`ifdef VON_SINGLE_STEP_EN
    .step(1'b0),
`endif
    .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_we(mem_we2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .alu_ac(alu_ac2), .alu_dr(alu_dr2), .alu_mode(alu_mode2),
    .alu_act(alu_act2), .alu_result(alu_result2),
    .pc(pc2), .halted(halted2)
  );

  // Behaviour of the external accumulator ALU.
  function automatic logic [7:0] alu_f(input logic [2:0] m, input logic [7:0] a,
                                       input logic [7:0] d);
    case (m)
      3'd0:    return a + d;
      3'd1:    return {d[6:0], 1'b0};
      3'd2:    return ~(a ^ d);
      3'd3:    return {1'b0, d[7:1]};
      3'd4:    return d;
      3'd6:    return 8'd0 - a;
      default: return a;
    endcase
  endfunction

  logic [7:0] alu_res_r = 8'h00, alu_res_r2 = 8'h00;
  always @(posedge alu_act)  alu_res_r  <= alu_f(alu_mode, alu_ac, alu_dr);
  always @(posedge alu_act2) alu_res_r2 <= alu_f(alu_mode2, alu_ac2, alu_dr2);
  assign alu_result  = alu_res_r;
  assign alu_result2 = alu_res_r2;

  // Memory: combinational read of the registered address; write at the end
  // of the cycle mem_we is high. The bench loads images via load_req.
  logic [7:0] mem [32];
  logic [7:0] mem_image [32];
  logic [7:0] mem2 [32];
  always @(posedge clk) begin
    if (load_req) for (int i = 0; i < 32; i++) mem[i] <= mem_image[i];
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata2 = mem2[mem_addr2];

  int n_checks = 0;
  int n_errors = 0;
  int last_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 32; i++) mem_image[i] = 8'hE0;
  endtask

  task automatic load_image();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; run = 1'b0; run2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // Load mem_image, reset, run until halted and compare with the model.
  task automatic run_prog(input string name);
    logic [7:0] rm [32];
    logic [7:0] m_ac, m_dr, ins;
    logic [4:0] m_pc;
    int e_cyc, e_re, e_we, e_act, n, n_re, n_we, n_act, n_both, n_post;
    bit m_done;
    for (int i = 0; i < 32; i++) rm[i] = mem_image[i];
    m_ac = 8'h00; m_dr = 8'h00; m_pc = 5'd0; m_done = 1'b0;
    e_cyc = 1; e_re = 0; e_we = 0; e_act = 0;   // +1: IDLE -> IF edge
    for (int k = 0; k < 40 && !m_done; k++) begin
      ins = rm[m_pc];
      m_pc = m_pc + 5'd1;
      e_re++;
      case (ins[7:5])
        3'b111: begin e_cyc += 2; m_done = 1'b1; end
        3'b101: begin rm[ins[4:0]] = m_ac; e_cyc += 3; e_we++; end
        3'b110: begin m_ac = alu_f(ins[7:5], m_ac, m_dr); e_cyc += 4; e_act++; end
        default: begin
          m_dr = rm[ins[4:0]];
          m_ac = alu_f(ins[7:5], m_ac, m_dr);
          e_cyc += 6; e_re++; e_act++;
        end
      endcase
    end

    load_image();
    apply_reset();
    run = 1'b1;
    n = 0; n_re = 0; n_we = 0; n_act = 0; n_both = 0;
    while (n < 400 && !halted) begin
      @(posedge clk); n++;
      @(negedge clk);
      n_re += int'(mem_re); n_we += int'(mem_we); n_act += int'(alu_act);
      if (mem_re && mem_we) n_both++;
    end
    last_cyc = n;
    check_eq({name, " halted"}, 32'(halted), 32'd1);
    check_eq({name, " cycles"}, 32'(n), 32'(e_cyc));
    check_eq({name, " ac"}, 32'(alu_ac), 32'(m_ac));
    check_eq({name, " pc"}, 32'(pc), 32'(m_pc));
    check_eq({name, " reads"}, 32'(n_re), 32'(e_re));
    check_eq({name, " writes"}, 32'(n_we), 32'(e_we));
    check_eq({name, " alu_act"}, 32'(n_act), 32'(e_act));
    check_eq({name, " re_and_we"}, 32'(n_both), 32'd0);
    n_post = 0;
    repeat (3) begin
      @(negedge clk);
      if (!halted || mem_re || mem_we) n_post++;
    end
    check_eq({name, " stays_halted"}, 32'(n_post), 32'd0);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s mem[%0d]", name, i), 32'(mem[i]), 32'(rm[i]));
    run = 1'b0;
  endtask

  // Wait (bounded) for the cycle where instruction `ins` is being fetched.
  task automatic wait_fetch(input logic [7:0] ins, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mem_re && mem_rdata == ins) seen = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n, cnt;
    logic [4:0] addrs [$];
    rst = 1'b1; run = 1'b1; run2 = 1'b0; load_req = 1'b0;
`ifdef VON_SINGLE_STEP_EN
    step = 1'b0;
`endif
    for (int i = 0; i < 32; i++) mem2[i] = 8'hE0;
    mem2[31] = 8'hC0;   // NEG at the last address, HALT after the wrap

    // Reset with run held high.
    clear_image();
    mem_image[0] = 8'hE0;
    load_image();
    @(negedge clk); rst = 1'b1; run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst mem_re", 32'(mem_re), 32'd0);
    check_eq("rst mem_we", 32'(mem_we), 32'd0);
    check_eq("rst mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst alu_act", 32'(alu_act), 32'd0);
    check_eq("rst alu_ac", 32'(alu_ac), 32'd0);
    check_eq("rst alu_dr", 32'(alu_dr), 32'd0);
    check_eq("rst alu_mode", 32'(alu_mode), 32'd0);
    check_eq("rst pc", 32'(pc), 32'd0);
    check_eq("rst halted", 32'(halted), 32'd0);
    check_eq("rst pc wrap inst", 32'(pc2), 32'd31);
    rst = 1'b0;

`ifndef VON_SINGLE_STEP_EN
    // First fetch: IDLE -> IF, then mem_re visible after the IF edge.
    n = 0; seen = 1'b0;
    while (n < 6 && !seen) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (mem_re) seen = 1'b1;
    end
    check_eq("first fetch seen", 32'(seen), 32'd1);
    check_eq("first fetch latency", 32'(n), 32'd2);
    check_eq("first fetch addr", 32'(mem_addr), 32'd0);

    // LOAD 10, ADD 11, STORE 12, HALT.
    clear_image();
    mem_image[0] = 8'h8A; mem_image[1] = 8'h0B; mem_image[2] = 8'hAC;
    mem_image[3] = 8'hE0; mem_image[10] = 8'h05; mem_image[11] = 8'h07;
    mem_image[12] = 8'h00;
    run_prog("prog_lash");
    check_eq("prog_lash mem12", 32'(mem[12]), 32'h0C);
    check_eq("prog_lash cycles_abs", 32'(last_cyc), 32'd18);

    // LOAD 16 (0x05), NEG, XNOR 17 (0xFB), HALT.
    clear_image();
    mem_image[0] = 8'h90; mem_image[1] = 8'hC0; mem_image[2] = 8'h51;
    mem_image[16] = 8'h05; mem_image[17] = 8'hFB;
    run_prog("prog_neg_xnor");
    check_eq("prog_neg_xnor ac_abs", 32'(alu_ac), 32'hFF);

    // Random straight-line programs in 0..15, data in 16..31.
    for (int t = 0; t < 8; t++) begin
      int len;
      logic [2:0] op;
      clear_image();
      for (int i = 16; i < 32; i++) mem_image[i] = 8'($urandom);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        op = 3'($urandom_range(0, 6));
        mem_image[i] = {op, 1'b1, 4'($urandom)};
      end
      run_prog($sformatf("rand%0d", t));
    end

    // PC wrap: NEG at 31, next fetch from 0.
    apply_reset();
    run2 = 1'b1; n = 0; cnt = 0;
    while (n < 20 && !halted2) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (mem_re2) addrs.push_back(mem_addr2);
      cnt += int'(mem_we2);
    end
    check_eq("wrap halted", 32'(halted2), 32'd1);
    check_eq("wrap fetches", 32'(addrs.size()), 32'd2);
    if (addrs.size() >= 2) begin
      check_eq("wrap fetch0", 32'(addrs[0]), 32'd31);
      check_eq("wrap fetch1", 32'(addrs[1]), 32'd0);
    end
    check_eq("wrap pc", 32'(pc2), 32'd1);
    check_eq("wrap writes", 32'(cnt), 32'd0);
    run2 = 1'b0;

    // Reset during S_EX of a NEG.
    clear_image();
    mem_image[0] = 8'h90; mem_image[1] = 8'hC0; mem_image[16] = 8'h05;
    load_image();
    apply_reset();
    run = 1'b1;
    wait_fetch(8'hC0, seen);
    check_eq("rst_ex fetch seen", 32'(seen), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ex ac before", 32'(alu_ac), 32'h05);
    @(posedge clk); #1 rst = 1'b0; run = 1'b0;
    @(negedge clk);
    check_eq("rst_ex alu_act", 32'(alu_act), 32'd0);
    check_eq("rst_ex ac", 32'(alu_ac), 32'd0);
    check_eq("rst_ex pc", 32'(pc), 32'd0);
    cnt = 0;
    repeat (4) begin @(negedge clk); cnt += int'(mem_re) + int'(alu_act) + int'(halted); end
    check_eq("rst_ex idle", 32'(cnt), 32'd0);

    // Reset during S_ST: the store must be dropped.
    clear_image();
    mem_image[0] = 8'h90; mem_image[1] = 8'hB4;
    mem_image[16] = 8'h33; mem_image[20] = 8'h11;
    load_image();
    apply_reset();
    run = 1'b1;
    wait_fetch(8'hB4, seen);
    check_eq("rst_st fetch seen", 32'(seen), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; run = 1'b0;
    cnt = 0;
    repeat (4) begin @(negedge clk); cnt += int'(mem_we); end
    check_eq("rst_st no write", 32'(cnt), 32'd0);
    check_eq("rst_st mem20", 32'(mem[20]), 32'h11);
`else
    // Single-step: LOAD 16, ADD 17, HALT.
    clear_image();
    mem_image[0] = 8'h90; mem_image[1] = 8'h11;
    mem_image[16] = 8'h05; mem_image[17] = 8'h07;
    load_image();
    apply_reset();
    run = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(mem_re); end
    check_eq("step no fetch", 32'(cnt), 32'd0);
    for (int p = 0; p < 2; p++) begin
      int n_act;
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      cnt = 0; n_act = 0;
      repeat (14) begin @(negedge clk); cnt += int'(mem_re); n_act += int'(alu_act); end
      check_eq($sformatf("step%0d reads", p), 32'(cnt), 32'd2);
      check_eq($sformatf("step%0d alu_act", p), 32'(n_act), 32'd1);
      check_eq($sformatf("step%0d ac", p), 32'(alu_ac), (p == 0) ? 32'h05 : 32'h0C);
      check_eq($sformatf("step%0d pc", p), 32'(pc), 32'(p + 1));
    end
    run = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
